// File: rtl/gate_tt_checker.sv
// Truth-table sequencer/checker wrapped around a 2-input gate: drives {a,b}=00..11, samples y, reports mismatches.
// Optional `GATE_TT_LOG_EN adds obs_tt, the y value observed for each vector.
module gate_tt_checker #(
  parameter logic [3:0]  EXPECT      = 4'b0111,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_mask
`ifdef GATE_TT_LOG_EN
  ,
  output logic [3:0] obs_tt
`endif
);

  localparam int unsigned HW        = 4;
  localparam int unsigned IW        = 2;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [HW-1:0] hold_cnt;

  logic       mismatch_c;
  logic [2:0] err_next_c;

  // Compare against the expected bit for the vector currently on the gate inputs
  always_comb begin
    mismatch_c = (y != EXPECT[idx]);
    err_next_c = err_cnt + 3'(mismatch_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      hold_cnt  <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_mask <= '0;
`ifdef GATE_TT_LOG_EN
      obs_tt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state     <= DRIVE;
            idx       <= '0;
            hold_cnt  <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_mask <= '0;
`ifdef GATE_TT_LOG_EN
            obs_tt    <= '0;
`endif
          end
        end
        DRIVE: begin
          // Abort wins over a coincident sample; partial results are kept
          if (abort) begin
            state    <= IDLE;
            idx      <= '0;
            hold_cnt <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            err_cnt <= err_next_c;
            if (mismatch_c) fail_mask[idx] <= 1'b1;
`ifdef GATE_TT_LOG_EN
            obs_tt[idx] <= y;
`endif
            if (idx == IDX_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next_c == 3'd0);
            end else begin
              idx      <= idx + IW'(1);
              hold_cnt <= '0;
              {a, b}   <= idx + IW'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          idx      <= '0;
          hold_cnt <= '0;
          a        <= 1'b0;
          b        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Scoreboard bench for gate_tt_checker: a behavioural gate with a random truth table sits on a/b/y.
module tb_gate_tt_checker;

  localparam logic [3:0]  EXPECT = 4'b0111;
  localparam int unsigned H      = 2;

  logic       clk = 1'b0;
  logic       rst, start, abort, y;
  logic       a, b, busy, done, pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_mask;
`ifdef GATE_TT_LOG_EN
  logic [3:0] obs_tt;
`endif

  logic [3:0] gate_tt;
  assign y = gate_tt[{a, b}];

  typedef struct {
    int         done_cyc;
    logic       pass;
    int         err;
    logic [3:0] mask;
    logic [3:0] obs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   run_start = 0;

  gate_tt_checker #(.EXPECT(EXPECT), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y(y),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_mask(fail_mask)
`ifdef GATE_TT_LOG_EN
    , .obs_tt(obs_tt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every done pulse; also checks the vector being driven
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        check("done_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("done_cycle", cyc, mon_e.done_cyc);
          check("pass", pass, mon_e.pass);
          check("err_cnt", err_cnt, mon_e.err);
          check("fail_mask", fail_mask, mon_e.mask);
          check("busy_at_done", busy, 0);
`ifdef GATE_TT_LOG_EN
          check("obs_tt", obs_tt, mon_e.obs);
`endif
        end
      end
      if (busy) check("vector", {a, b}, (cyc - run_start - 1) / int'(H));
      if (!busy && !done) check("idle_ab", {a, b}, 0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ab"}, {a, b}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_mask"}, fail_mask, 0);
`ifdef GATE_TT_LOG_EN
    check({tag, "_obs"}, obs_tt, 0);
`endif
  endtask

  // Full run; when poke is set, start is re-pulsed mid-run and during the done cycle
  task automatic do_run(input logic [3:0] tt, input bit poke);
    exp_t e;
    gate_tt    = tt;
    e.done_cyc = cyc + 4 * int'(H) + 1;
    e.mask     = tt ^ EXPECT;
    e.err      = $countones(e.mask);
    e.pass     = (e.err == 0);
    e.obs      = tt;
    sb.push_back(e);
    run_start = cyc;
    start = 1'b1;
    step();
    for (int t = 1; t <= 4 * int'(H) + 1; t++) begin
      start = poke && (t == 3 || t == 4 * int'(H) + 1);
      step();
    end
    start = 1'b0;
    check("run_completed", sb.size(), 0);
    check("no_restart", busy, 0);
    repeat (2) step();
    check("pass_held", pass, e.pass);
    check("err_held", err_cnt, e.err);
  endtask

  // Abort asserted during cycle k of a run (k counted from the start cycle)
  task automatic do_abort(input logic [3:0] tt, input int k);
    logic [3:0] pm;
    gate_tt   = tt;
    run_start = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (k - 1) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    pm = '0;
    for (int j = 0; j < 4; j++)
      if (int'(H) * (j + 1) <= k - 1) pm[j] = tt[j] ^ EXPECT[j];
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ab", {a, b}, 0);
    check("abort_pass", pass, 0);
    check("abort_err", err_cnt, $countones(pm));
    check("abort_mask", fail_mask, pm);
    repeat (3) step();
    check("abort_stays_idle", busy, 0);
  endtask

  // Asynchronous reset applied between clock edges k cycles into a run
  task automatic do_reset_mid(input logic [3:0] tt, input int k);
    gate_tt   = tt;
    run_start = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (k - 1) step();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    rst = 1'b0;
    step();
    check("post_rst_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; gate_tt = EXPECT;
    #3;
    check_reset_outputs("reset");
    step();
    step();
    rst = 1'b0;
    step();

    do_run(4'b0111, 1'b0);   // nand
    do_run(4'b1000, 1'b0);   // and
    do_run(4'b1111, 1'b0);   // y tied high
    do_abort(4'b0111, 4);
    do_run(4'b0111, 1'b0);
    do_run(4'b0111, 1'b1);

    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);
    repeat (3) step();
    check("start_abort_no_run", busy, 0);

    do_reset_mid(4'b0111, 5);
    do_run(4'b0111, 1'b0);

    for (int i = 0; i < 20; i++)
      do_run(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++)
      do_abort(4'($urandom_range(0, 15)), $urandom_range(1, 4 * int'(H)));
    do_reset_mid(4'($urandom_range(0, 15)), $urandom_range(1, 4 * int'(H)));
    do_run(4'b0110, 1'b1);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
